// File: rtl/decap_packet.sv
// decap_packet: strips Aurora headers and reassembles 19 payload slices into one DFX word,
// dropping words for other routers and rejecting out-of-order frames.
module decap_packet #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int NUMBER_PACKET = 19,
    parameter int TTL_WIDTH = 2,
    parameter int HEADER_WIDTH = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HEADER_WIDTH,
    parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] ROUTER_ID = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    input  logic                         data_recv_valid,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
    output logic                         decap_valid,
    output logic                         frame_error,
    output logic                         busy
);
    localparam int SEQ_W = $clog2(NUMBER_PACKET);
    localparam int LAST = NUMBER_PACKET - 1;
    localparam int BUF_W = LAST * PAYLOAD_WIDTH;
    localparam int TAIL_W = DATA_DFX_WIDTH - BUF_W;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                    state;
    logic [SEQ_W-1:0]          exp_idx;
    logic [BUF_W-1:0]          buffer;
    logic [HEADER_WIDTH-1:0]   saved_header;
    logic [HEADER_WIDTH-1:0]   header;
    logic [PAYLOAD_WIDTH-1:0]  payload;
    logic [SEQ_W-1:0]          seq;
    logic                      accept, in_order, start, store;

    assign header   = data_recv[HEADER_WIDTH-1:0];
    assign payload  = data_recv[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
    assign seq      = header[RECOGNIZE_ROUTER_WIDTH +: SEQ_W];
    assign accept   = data_recv_valid && header[RECOGNIZE_ROUTER_WIDTH-1:0] == ROUTER_ID;
    assign in_order = accept && state == COLLECT && seq == exp_idx;
    // seq 0 always (re)starts a frame, even when it aborts a partial one
    assign start    = accept && !in_order && seq == '0;
    assign store    = (in_order && exp_idx != SEQ_W'(LAST)) || start;
    assign busy     = state == COLLECT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            exp_idx         <= '0;
            buffer          <= '0;
            saved_header    <= '0;
            data_dfx_recv   <= '0;
            header_pkt_recv <= '0;
            decap_valid     <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            decap_valid <= 1'b0;
            frame_error <= accept && !in_order && (state == COLLECT || seq != '0);
            if (in_order && exp_idx == SEQ_W'(LAST)) begin
                data_dfx_recv   <= {payload[TAIL_W-1:0], buffer};
                header_pkt_recv <= saved_header;
                decap_valid     <= 1'b1;
                exp_idx         <= '0;
                state           <= IDLE;
            end else if (in_order) begin
                exp_idx <= exp_idx + 1'b1;
            end else if (start) begin
                saved_header <= header;
                exp_idx      <= SEQ_W'(1);
                state        <= COLLECT;
            end else if (accept) begin
                exp_idx <= '0;
                state   <= IDLE;
            end
            for (int i = 0; i < LAST; i++)
                if (store && seq == SEQ_W'(i))
                    buffer[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= payload;
        end
    end
endmodule

// File: tb/tb_decap_packet.sv
// tb_decap_packet: directed scenarios plus random traffic against a queue-based frame model.
module tb_decap_packet;
    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   data_recv;
    logic          data_recv_valid;
    logic [1033:0] data_dfx_recv;
    logic [8:0]    header_pkt_recv;
    logic          decap_valid, frame_error, busy;

    int checks = 0;
    int errors = 0;

    logic [54:0]   q[$];
    logic [8:0]    m_shdr = '0;
    logic [1033:0] m_data = '0;
    logic [8:0]    m_hdr = '0;
    logic          m_dv = 1'b0, m_fe = 1'b0;
    int            frames = 0;

    decap_packet dut (
        .clk(clk), .rst(rst), .data_recv(data_recv), .data_recv_valid(data_recv_valid),
        .data_dfx_recv(data_dfx_recv), .header_pkt_recv(header_pkt_recv),
        .decap_valid(decap_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1033:0] got, input logic [1033:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (low 64 bits shown, %0d bits differ)",
                   tag, got[63:0], want[63:0], $countones(got ^ want));
        end
    endtask

    task automatic check_all();
        check("decap_valid", 1034'(decap_valid), 1034'(m_dv));
        check("frame_error", 1034'(frame_error), 1034'(m_fe));
        check("busy", 1034'(busy), 1034'(q.size() > 0));
        check("data_dfx_recv", data_dfx_recv, m_data);
        check("header_pkt_recv", 1034'(header_pkt_recv), 1034'(m_hdr));
    endtask

    // A frame is the queue of in-order payloads; it completes when 19 are collected.
    task automatic model(input logic v, input logic [63:0] w);
        logic [1033:0] f;
        int seq;
        m_dv = 1'b0;
        m_fe = 1'b0;
        if (v && w[1:0] == 2'b00) begin
            seq = int'(w[6:2]);
            if (seq == q.size()) begin
                if (seq == 0) m_shdr = w[8:0];
                q.push_back(w[63:9]);
            end else if (seq == 0) begin
                m_fe = 1'b1;
                q.delete();
                q.push_back(w[63:9]);
                m_shdr = w[8:0];
            end else begin
                m_fe = 1'b1;
                q.delete();
            end
            if (q.size() == 19) begin
                f = '0;
                for (int k = 0; k < 18; k++) f |= 1034'(q[k]) << (k * 55);
                f |= 1034'(q[18][43:0]) << 990;
                m_data = f;
                m_hdr = m_shdr;
                m_dv = 1'b1;
                frames++;
                q.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic [63:0] w);
        data_recv = w;
        data_recv_valid = v;
        @(posedge clk);
        #1;
        model(v, w);
        check_all();
    endtask

    function automatic logic [63:0] word_of(input logic [1033:0] f, input int k, input logic [1:0] id);
        logic [54:0] p;
        p = (k == 18) ? {11'($urandom()), f[1033:990]} : f[k*55 +: 55];
        return {p, 2'($urandom()), 5'(k), id};
    endfunction

    function automatic logic [1033:0] rand_frame();
        logic [1033:0] f = '0;
        for (int i = 0; i < 33; i++) f = (f << 32) | 1034'($urandom());
        return f;
    endfunction

    task automatic send(input logic [1033:0] f, input int first, input int last,
                        input int gap_a, input int gap_b, input bit il);
        for (int k = first; k <= last; k++) begin
            step(1'b1, word_of(f, k, 2'b00));
            if (il) step(1'b1, word_of(rand_frame(), $urandom_range(18), 2'b01));
            if (k == gap_a || k == gap_b) repeat (3) step(1'b0, {$urandom(), $urandom()});
        end
    endtask

    task automatic check_reset_zero();
        m_dv = 1'b0; m_fe = 1'b0; m_data = '0; m_hdr = '0; m_shdr = '0;
        q.delete();
        check_all();
    endtask

    initial begin
        logic [1033:0] fa;
        logic [1023:0] pat;
        rst = 1'b1;
        data_recv = '0;
        data_recv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero();
        @(negedge clk) rst = 1'b0;

        pat = {128{8'hA5}};
        fa = {10'h3FF, pat};
        send(fa, 0, 18, -1, -1, 1'b0);
        step(1'b0, '0);
        send(fa, 0, 18, 4, 17, 1'b0);
        step(1'b0, '0);
        send(rand_frame(), 0, 18, -1, -1, 1'b1);

        send(rand_frame(), 0, 6, -1, -1, 1'b0);
        step(1'b1, word_of(rand_frame(), 9, 2'b00));
        step(1'b1, word_of(rand_frame(), 0, 2'b00));
        send(rand_frame(), 0, 18, -1, -1, 1'b0);

        fa = rand_frame();
        send(rand_frame(), 0, 9, -1, -1, 1'b0);
        send(fa, 0, 18, -1, -1, 1'b0);

        send(rand_frame(), 0, 12, -1, -1, 1'b0);
        @(negedge clk) rst = 1'b1;
        #1;
        check_reset_zero();
        @(negedge clk) rst = 1'b0;
        send(rand_frame(), 0, 18, -1, -1, 1'b0);
        send(rand_frame(), 0, 18, -1, -1, 1'b0);

        fa = rand_frame();
        for (int n = 0; n < 2000; n++) begin
            int s;
            logic [1:0] id;
            if (q.size() == 0) fa = rand_frame();
            s = ($urandom_range(14) == 0) ? $urandom_range(31) : q.size();
            id = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            step($urandom_range(3) != 0, (s < 19) ? word_of(fa, s, id)
                 : {$urandom(), 23'($urandom()), 5'(s), id});
        end
        check("frames_seen", 1034'(frames > 10), 1034'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decap_packet.md
# decap_packet

Receive-side counterpart of the packet encapsulator: it takes the stream of 64-bit Aurora words arriving from the link and strips the 9-bit header from each one. It reassembles the 19 payload slices into one 1034-bit DFX word (address plus data) and presents that word to the input-port logic with a one-cycle valid strobe. It sits between the Aurora RX user interface and the input-port buffer. It filters words not addressed to this router and rejects out-of-order frames.

## Interface
- DATA_WIDTH, 1024, data part of a DFX word
- ADDR_WIDTH, 10, address part of a DFX word
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembled word width
- RECOGNIZE_ROUTER_WIDTH, 2, router-ID field width
- NUMBER_PACKET, 19, Aurora words per frame
- TTL_WIDTH, 2, TTL field width
- HEADER_WIDTH, 9, RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH
- AURORA_DATA_WIDTH, 64, link word width
- PAYLOAD_WIDTH, 55, AURORA_DATA_WIDTH - HEADER_WIDTH
- ROUTER_ID, 2'b00, ID this port accepts
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- data_recv  in  64  Aurora RX word; header in [8:0], payload in [63:9]
- data_recv_valid  in  1  data_recv valid this cycle; no backpressure exists
- data_dfx_recv  out  1034  last completed frame; held until the next frame completes
- header_pkt_recv  out  9  header of word 0 of the last completed frame
- decap_valid  out  1  one-cycle pulse: data_dfx_recv/header_pkt_recv just updated
- frame_error  out  1  one-cycle pulse: sequence violation detected
- busy  out  1  high while a frame is partially collected

## Operation
- Header fields:
  - [1:0] router ID.
  - [6:2] sequence index, 0..18.
  - [8:7] TTL, passed through and not checked.
- Word k (0..17) carries frame bits [k*55 +: 55].
- Word 18 carries frame bits [1033:990] in payload [43:0]. Payload [54:44] is ignored.
- A word is "accepted" only when data_recv_valid=1 and header[1:0]==ROUTER_ID.
  - Non-matching words are dropped silently in every state: no state, counter or error change.
- Registers:
  - 990-bit assembly buffer.
  - 5-bit expected index, exp_idx.
  - Saved word-0 header.
  - Output registers, kept separate from the assembly buffer so the output stays stable while the next frame assembles.
- State IDLE (exp_idx=0):
  - Accepted word with seq==0: store slice 0, save header, exp_idx←1, go to COLLECT.
  - Accepted word with seq≠0: frame_error pulse, stay in IDLE.
- State COLLECT:
  - Accepted word with seq==exp_idx<18: store slice, exp_idx++.
  - Accepted word with seq==exp_idx==18: data_dfx_recv←{payload[43:0], buffer}, header_pkt_recv←saved header, decap_valid pulse, exp_idx←0, go to IDLE.
  - Accepted word with seq≠exp_idx: frame_error pulse and discard the partial frame.
    - If that word's seq==0, it starts a new frame: slice 0 stored, exp_idx←1, stay in COLLECT.
    - Otherwise go to IDLE.
- Idle gaps (valid low) inside a frame are allowed without limit; state holds.
- busy = (state==COLLECT).

## Timing
- Reset values: data_dfx_recv=0, header_pkt_recv=0, decap_valid=0, frame_error=0, busy=0, state IDLE, exp_idx=0, buffer=0.
- Reset asserted mid-frame clears everything immediately and discards the partial frame.
- The first accepted word after reset release must carry seq 0.
- Latency: decap_valid rises in the cycle after the clock edge that accepts word 18.
  - Back-to-back minimum is 19 cycles per frame, so decap_valid can pulse every 19 cycles.
- The word 0 of the next frame may arrive in the cycle directly after word 18. It is accepted normally (state is already IDLE).
- decap_valid and frame_error are never high together. Each is high for exactly one cycle per event.
- Only accepted words update the buffer; valid-low cycles change nothing.

## Test plan
- Frame with data_dfx = 1034'h3FF<<1024 | 1024'hA5 repeated, 19 consecutive valid words, seq 0..18, ID 00 -> decap_valid pulses once, 1 cycle after word 18; data_dfx_recv equals the original frame; header_pkt_recv equals the word-0 header.
- Same frame with 3 valid-low cycles inserted after words 4 and 17 -> identical output; decap_valid 1 cycle after word 18; busy stays high throughout the gaps.
- Words with ID 01 interleaved between every ID-00 word -> ID-01 words are ignored; one correct frame out, no frame_error.
- In COLLECT at exp_idx=7, send a word with seq 9 -> frame_error pulse, busy=0, data_dfx_recv unchanged. Then send a word with seq 0 followed by a full frame -> correct decap_valid.
- At exp_idx=10, send a word with seq 0 -> frame_error pulse, busy stays 1. Then send seq 1..18 -> decap_valid with the new frame.
- Assert rst at word 12 of a frame, release, send a full new frame -> all outputs are 0 during reset; afterwards only the new frame is delivered.
